// File: rtl/mem_access_initiator.sv
// Single-outstanding memory bus initiator shared by an instruction-fetch port and a
// load/store port; arbitrates, checks alignment, drives a fixed-latency bus, extends loads.
module mem_access_initiator #(
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_ack,
   output logic [31:0] fetch_instr,
   output logic        fetch_err,
   input  logic        ls_req,
   input  logic        ls_write,
   input  logic [1:0]  ls_size,
   input  logic        ls_signed,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_ack,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic        req_mem_access,
   output logic [31:0] addr,
   output logic [31:0] data_out,
   output logic        access_type,
   output logic [1:0]  access_size,
   input  logic [31:0] data_in,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_t;

   state_t      r_state;
   logic        r_owner_ls;
   logic        r_write;
   logic        r_signed;
   logic [1:0]  r_size;
   logic [3:0]  r_count;
   logic        r_last_ls;
   logic        r_fetch_ack;
   logic        r_ls_ack;
   logic [31:0] r_fetch_instr;
   logic [31:0] r_ls_rdata;
   logic        r_req_mem_access;
   logic [31:0] r_addr;
   logic [31:0] r_data_out;
   logic        r_access_type;
   logic [1:0]  r_access_size;

   logic        w_idle;
   logic        w_fetch_misaligned;
   logic        w_ls_misaligned;
   logic        w_fetch_ok;
   logic        w_ls_ok;
   logic        w_grant_ls;
   logic        w_grant_fetch;
   logic [31:0] w_wdata_placed;

   function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [1:0] sz,
                                               input logic sgn);
      case (sz)
         2'd0:    extend_load = {{24{sgn & d[7]}}, d[7:0]};
         2'd1:    extend_load = {{16{sgn & d[15]}}, d[15:0]};
         default: extend_load = d;
      endcase
   endfunction

   assign w_idle             = (r_state == IDLE) && !rst;
   assign w_fetch_misaligned = (fetch_addr[1:0] != 2'b00);
   assign w_ls_misaligned    = (ls_size == 2'd3) ||
                               (ls_size == 2'd1 && ls_addr[0]) ||
                               (ls_size == 2'd2 && ls_addr[1:0] != 2'b00);
   assign w_fetch_ok         = fetch_req && !w_fetch_misaligned;
   assign w_ls_ok            = ls_req && !w_ls_misaligned;
   // Contention goes to ls unless ls completed last, so neither port can starve.
   assign w_grant_ls         = w_ls_ok && (!w_fetch_ok || !r_last_ls);
   assign w_grant_fetch      = w_fetch_ok && !w_grant_ls;

   // Errors are raised combinationally in IDLE so the client sees them in the request
   // cycle and drops req before IDLE could sample the same bad request again.
   assign fetch_err = w_idle && fetch_req && w_fetch_misaligned;
   assign ls_err    = w_idle && ls_req && w_ls_misaligned;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_wdata_placed = ls_wdata;
      case (ls_size)
         2'd0:    w_wdata_placed = {24'h0, ls_wdata[7:0]};
         2'd1:    w_wdata_placed = {16'h0, ls_wdata[15:0]};
         default: w_wdata_placed = ls_wdata;
      endcase
   end

   // NOTE: state and registered outputs use non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= IDLE;
         r_owner_ls       <= 1'b0;
         r_write          <= 1'b0;
         r_signed         <= 1'b0;
         r_size           <= 2'd0;
         r_count          <= 4'd0;
         r_last_ls        <= 1'b0;
         r_fetch_ack      <= 1'b0;
         r_ls_ack         <= 1'b0;
         r_fetch_instr    <= 32'h0;
         r_ls_rdata       <= 32'h0;
         r_req_mem_access <= 1'b0;
         r_addr           <= 32'h0;
         r_data_out       <= 32'h0;
         r_access_type    <= 1'b0;
         r_access_size    <= 2'd0;
      end else begin
         r_req_mem_access <= 1'b0;
         r_fetch_ack      <= 1'b0;
         r_ls_ack         <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_ls) begin
                  r_owner_ls       <= 1'b1;
                  r_write          <= ls_write;
                  r_signed         <= ls_signed;
                  r_size           <= ls_size;
                  r_addr           <= ls_addr;
                  r_access_type    <= ls_write;
                  r_access_size    <= ls_size;
                  if (ls_write) r_data_out <= w_wdata_placed;
                  r_req_mem_access <= 1'b1;
                  r_state          <= REQ;
               end else if (w_grant_fetch) begin
                  r_owner_ls       <= 1'b0;
                  r_write          <= 1'b0;
                  r_signed         <= 1'b0;
                  r_size           <= 2'd2;
                  r_addr           <= fetch_addr;
                  r_access_type    <= 1'b0;
                  r_access_size    <= 2'd2;
                  r_req_mem_access <= 1'b1;
                  r_state          <= REQ;
               end
            end
            REQ: begin
               if (r_write) begin
                  r_ls_ack <= 1'b1;
                  r_state  <= ACK;
               end else begin
                  r_count <= 4'(MEM_LATENCY);
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (r_count == 4'd1) begin
                  if (r_owner_ls) begin
                     r_ls_rdata <= extend_load(data_in, r_size, r_signed);
                     r_ls_ack   <= 1'b1;
                  end else begin
                     r_fetch_instr <= data_in;
                     r_fetch_ack   <= 1'b1;
                  end
                  r_state <= ACK;
               end else begin
                  r_count <= r_count - 4'd1;
               end
            end
            ACK: begin
               r_last_ls <= r_owner_ls;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign fetch_ack      = r_fetch_ack;
   assign fetch_instr    = r_fetch_instr;
   assign ls_ack         = r_ls_ack;
   assign ls_rdata       = r_ls_rdata;
   assign req_mem_access = r_req_mem_access;
   assign addr           = r_addr;
   assign data_out       = r_data_out;
   assign access_type    = r_access_type;
   assign access_size    = r_access_size;
   assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_mem_access_initiator.sv
// Scoreboard bench: stimulus pushes expected bus/ack/err events with their cycle numbers,
// a negedge monitor pops and compares each event the DUTs present.
module tb_mem_access_initiator;

   typedef enum int {EV_BUS, EV_FACK, EV_LACK, EV_FERR, EV_LERR} ev_t;
   typedef struct {
      ev_t         kind;
      int          cyc;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  ts;
      bit          chk_d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0, ls_req = 1'b0, ls_write = 1'b0, ls_signed = 1'b0;
   logic [31:0] fetch_addr = '0, ls_addr = '0, ls_wdata = '0, data_in = '0;
   logic [1:0]  ls_size = '0;
   logic        fetch_ack, fetch_err, ls_ack, ls_err, req_mem_access, access_type, busy;
   logic [31:0] fetch_instr, ls_rdata, addr, data_out;
   logic [1:0]  access_size;

   logic        fetch_req_3 = 1'b0;
   logic [31:0] fetch_addr_3 = '0, data_in_3 = '0;
   logic        fetch_ack_3, fetch_err_3, ls_ack_3, ls_err_3, req_mem_access_3, access_type_3, busy_3;
   logic [31:0] fetch_instr_3, ls_rdata_3, addr_3, data_out_3;
   logic [1:0]  access_size_3;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          bus_cyc0 = -100, bus_cyc1 = -100;
   logic [31:0] mem_val = '0, mem_val_3 = '0;
   exp_t        q0[$], q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_initiator #(.MEM_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
      .fetch_instr(fetch_instr), .fetch_err(fetch_err),
      .ls_req(ls_req), .ls_write(ls_write), .ls_size(ls_size), .ls_signed(ls_signed),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .req_mem_access(req_mem_access), .addr(addr), .data_out(data_out),
      .access_type(access_type), .access_size(access_size), .data_in(data_in), .busy(busy)
   );

   mem_access_initiator #(.MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req_3), .fetch_addr(fetch_addr_3), .fetch_ack(fetch_ack_3),
      .fetch_instr(fetch_instr_3), .fetch_err(fetch_err_3),
      .ls_req(1'b0), .ls_write(1'b0), .ls_size(2'd0), .ls_signed(1'b0),
      .ls_addr(32'h0), .ls_wdata(32'h0), .ls_ack(ls_ack_3), .ls_rdata(ls_rdata_3), .ls_err(ls_err_3),
      .req_mem_access(req_mem_access_3), .addr(addr_3), .data_out(data_out_3),
      .access_type(access_type_3), .access_size(access_size_3), .data_in(data_in_3), .busy(busy_3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
      end
   endtask

   function automatic void push(input int inst, input ev_t k, input int c, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] ts, input bit chk_d);
      exp_t e;
      e = '{kind: k, cyc: c, a: a, d: d, ts: ts, chk_d: chk_d};
      if (inst == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   task automatic observe(input int inst, input ev_t k, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] ts);
      exp_t e;
      bit   have = 1'b0;
      if (inst == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      else if (inst == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
         checks++;
         errors++;
         $display("FAIL unexpected %s on dut%0d at cycle %0d: got d=%h required no event",
                  k.name(), inst, cyc, d);
      end else begin
         check("event kind", 32'(k), 32'(e.kind));
         check($sformatf("%s cycle", k.name()), 32'(cyc), 32'(e.cyc));
         if (k == EV_BUS) begin
            check("bus addr", a, e.a);
            check("bus type/size", {29'h0, ts}, {29'h0, e.ts});
            if (e.chk_d) check("bus data_out", d, e.d);
         end else if (e.chk_d) begin
            check($sformatf("%s data", k.name()), d, e.d);
         end
      end
   endtask

   always @(negedge clk) begin
      if (req_mem_access) begin
         bus_cyc0 = cyc;
         observe(0, EV_BUS, addr, data_out, {access_type, access_size});
      end
      if (fetch_ack) observe(0, EV_FACK, 32'h0, fetch_instr, 3'b0);
      if (ls_ack)    observe(0, EV_LACK, 32'h0, ls_rdata, 3'b0);
      if (fetch_err) observe(0, EV_FERR, 32'h0, 32'h0, 3'b0);
      if (ls_err)    observe(0, EV_LERR, 32'h0, 32'h0, 3'b0);
      if (req_mem_access_3) begin
         bus_cyc1 = cyc;
         observe(1, EV_BUS, addr_3, data_out_3, {access_type_3, access_size_3});
      end
      if (fetch_ack_3) observe(1, EV_FACK, 32'h0, fetch_instr_3, 3'b0);
      if (ls_ack_3)    observe(1, EV_LACK, 32'h0, ls_rdata_3, 3'b0);
      if (fetch_err_3) observe(1, EV_FERR, 32'h0, 32'h0, 3'b0);
      if (ls_err_3)    observe(1, EV_LERR, 32'h0, 32'h0, 3'b0);
   end

   // Responder: read data is valid only in the cycle exactly MEM_LATENCY after the request.
   always @(posedge clk) begin
      #1;
      data_in   = (cyc == bus_cyc0 + 1) ? mem_val   : (32'hBAD0_0000 ^ 32'(cyc));
      data_in_3 = (cyc == bus_cyc1 + 3) ? mem_val_3 : (32'hBAD1_0000 ^ 32'(cyc));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      check("rst req_mem_access", {31'h0, req_mem_access}, 32'h0);
      check("rst addr", addr, 32'h0);
      check("rst data_out", data_out, 32'h0);
      check("rst access_type", {31'h0, access_type}, 32'h0);
      check("rst access_size", {30'h0, access_size}, 32'h0);
      check("rst fetch_ack", {31'h0, fetch_ack}, 32'h0);
      check("rst ls_ack", {31'h0, ls_ack}, 32'h0);
      check("rst fetch_err", {31'h0, fetch_err}, 32'h0);
      check("rst ls_err", {31'h0, ls_err}, 32'h0);
      check("rst fetch_instr", fetch_instr, 32'h0);
      check("rst ls_rdata", ls_rdata, 32'h0);
      check("rst busy", {31'h0, busy}, 32'h0);
   endtask

   task automatic fetch_op(input logic [31:0] a, input logic [31:0] val, input bit err);
      int t = cyc;
      fetch_req = 1'b1; fetch_addr = a; mem_val = val;
      if (err) begin
         push(0, EV_FERR, t, 32'h0, 32'h0, 3'b0, 1'b0);
         tick(1);
      end else begin
         push(0, EV_BUS, t + 1, a, 32'h0, 3'b010, 1'b0);
         push(0, EV_FACK, t + 3, 32'h0, val, 3'b0, 1'b1);
         tick(4);
      end
      fetch_req = 1'b0;
      tick(1);
   endtask

   task automatic ls_op(input bit wr, input logic [1:0] sz, input bit sgn, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] val, input bit err,
                        input logic [31:0] exp_d);
      int t = cyc;
      ls_req = 1'b1; ls_write = wr; ls_size = sz; ls_signed = sgn; ls_addr = a; ls_wdata = wd;
      mem_val = val;
      if (err) begin
         push(0, EV_LERR, t, 32'h0, 32'h0, 3'b0, 1'b0);
         tick(1);
      end else if (wr) begin
         push(0, EV_BUS, t + 1, a, exp_d, {1'b1, sz}, 1'b1);
         push(0, EV_LACK, t + 2, 32'h0, 32'h0, 3'b0, 1'b0);
         tick(3);
      end else begin
         push(0, EV_BUS, t + 1, a, 32'h0, {1'b0, sz}, 1'b0);
         push(0, EV_LACK, t + 3, 32'h0, exp_d, 3'b0, 1'b1);
         tick(4);
      end
      ls_req = 1'b0;
      tick(1);
   endtask

   initial begin
      int t;
      tick(3);
      check_reset_outputs();
      rst = 1'b0;
      tick(1);

      fetch_op(32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
      ls_op(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'h0000_0080, 1'b0, 32'hFFFF_FF80);
      ls_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 32'h0000_0080);
      ls_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000_8001, 1'b0, 32'hFFFF_8001);
      ls_op(1'b0, 2'd1, 1'b0, 32'h14, 32'h0, 32'hFFFF_1234, 1'b0, 32'h0000_1234);
      ls_op(1'b0, 2'd2, 1'b1, 32'h18, 32'h0, 32'h89AB_CDEF, 1'b0, 32'h89AB_CDEF);
      ls_op(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_5678, 32'h0, 1'b0, 32'h0000_5678);
      ls_op(1'b1, 2'd0, 1'b0, 32'h7, 32'hAABB_CCDD, 32'h0, 1'b0, 32'h0000_00DD);
      ls_op(1'b1, 2'd2, 1'b0, 32'h8, 32'hAABB_CCDD, 32'h0, 1'b0, 32'hAABB_CCDD);
      ls_op(1'b0, 2'd2, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, 32'h0);
      ls_op(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0);
      ls_op(1'b0, 2'd1, 1'b0, 32'h1, 32'h0, 32'h0, 1'b1, 32'h0);
      fetch_op(32'h0000_0102, 32'h0, 1'b1);

      // Both ports erroring in the same cycle.
      t = cyc;
      fetch_req = 1'b1; fetch_addr = 32'h1;
      ls_req = 1'b1; ls_write = 1'b0; ls_size = 2'd2; ls_addr = 32'h2;
      push(0, EV_FERR, t, 32'h0, 32'h0, 3'b0, 1'b0);
      push(0, EV_LERR, t, 32'h0, 32'h0, 3'b0, 1'b0);
      tick(1);
      fetch_req = 1'b0; ls_req = 1'b0;
      tick(1);

      // A misaligned fetch must not block a legal store in the same cycle.
      t = cyc;
      fetch_req = 1'b1; fetch_addr = 32'h3;
      ls_req = 1'b1; ls_write = 1'b1; ls_size = 2'd0; ls_addr = 32'h21; ls_wdata = 32'h0000_015A;
      push(0, EV_FERR, t, 32'h0, 32'h0, 3'b0, 1'b0);
      push(0, EV_BUS, t + 1, 32'h21, 32'h0000_005A, 3'b100, 1'b1);
      push(0, EV_LACK, t + 2, 32'h0, 32'h0, 3'b0, 1'b0);
      tick(1);
      fetch_req = 1'b0;
      tick(2);
      ls_req = 1'b0;
      tick(1);

      // Reset while waiting for read data: no ack, outputs back to reset values.
      t = cyc;
      fetch_req = 1'b1; fetch_addr = 32'h300; mem_val = 32'h0000_0077;
      push(0, EV_BUS, t + 1, 32'h300, 32'h0, 3'b010, 1'b0);
      tick(1);
      check("busy in REQ", {31'h0, busy}, 32'h1);
      tick(1);
      rst = 1'b1; fetch_req = 1'b0;
      tick(1);
      check_reset_outputs();
      rst = 1'b0;
      tick(3);
      fetch_op(32'h0000_0304, 32'hCAFE_F00D, 1'b0);

      // Continuous contention alternates ls, fetch, ls, fetch (last completed was fetch).
      t = cyc;
      mem_val = 32'h1357_9BDF;
      fetch_req = 1'b1; fetch_addr = 32'h400;
      ls_req = 1'b1; ls_write = 1'b0; ls_size = 2'd2; ls_signed = 1'b0; ls_addr = 32'h500;
      push(0, EV_BUS, t + 1, 32'h500, 32'h0, 3'b010, 1'b0);
      push(0, EV_LACK, t + 3, 32'h0, 32'h1357_9BDF, 3'b0, 1'b1);
      push(0, EV_BUS, t + 5, 32'h400, 32'h0, 3'b010, 1'b0);
      push(0, EV_FACK, t + 7, 32'h0, 32'h1357_9BDF, 3'b0, 1'b1);
      push(0, EV_BUS, t + 9, 32'h500, 32'h0, 3'b010, 1'b0);
      push(0, EV_LACK, t + 11, 32'h0, 32'h1357_9BDF, 3'b0, 1'b1);
      push(0, EV_BUS, t + 13, 32'h400, 32'h0, 3'b010, 1'b0);
      push(0, EV_FACK, t + 15, 32'h0, 32'h1357_9BDF, 3'b0, 1'b1);
      tick(16);
      fetch_req = 1'b0; ls_req = 1'b0;
      tick(1);

      // MEM_LATENCY=3 instance: read request at T acks at T+5.
      t = cyc;
      fetch_req_3 = 1'b1; fetch_addr_3 = 32'h600; mem_val_3 = 32'h0BAD_F00D;
      push(1, EV_BUS, t + 1, 32'h600, 32'h0, 3'b010, 1'b0);
      push(1, EV_FACK, t + 5, 32'h0, 32'h0BAD_F00D, 3'b0, 1'b1);
      tick(6);
      fetch_req_3 = 1'b0;
      tick(4);

      check("dut pending expectations", 32'(q0.size()), 32'h0);
      check("dut3 pending expectations", 32'(q1.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
